spi_xfer_ctrl: RTL
==================

// Module: spi_xfer_ctrl
// PURPOSE
//  Sequences multi-byte SPI transfers for the SPI_CNT register path. Fetches bytes from the
//  TX buffer, shifts them out MSB-first (SPI mode 0) on the flash/MCU bus or the TF bus, and
//  writes received bytes to the RX buffer. Runs entirely in the FastClk domain; Start/Abort
//  arrive already synchronised from the SClk register side.
// PARAMETERS
//  BUF_AW  9  buffer address width (bytes); also the Length width
//  DIV_W   3  width of ClkDiv; SPI half-period = 2**ClkDiv FastClk cycles
// PORTS
//  FastClk    in   1       sole clock; all state on rising edge
//  nReset     in   1       asynchronous, active-low reset
//  Start      in   1       1-cycle pulse: begin transfer (ignored while Busy)
//  Abort      in   1       1-cycle pulse: stop transfer immediately
//  Length     in   BUF_AW  bytes to transfer minus 1
//  Mode       in   2       0 TX only (no RX writes), 1 RX only (send 0xFF), 2/3 exchange
//  DevSel     in   2       0 none (SPI bus, no CS), 1 flash, 2 MCU, 3 TF card
//  ClkDiv     in   DIV_W   SPI clock divider exponent
//  TxAddr     out  BUF_AW  TX buffer read address; data valid 1 cycle later
//  TxData     in   8       TX buffer read data
//  RxAddr     out  BUF_AW  RX buffer write address
//  RxData     out  8       RX buffer write data
//  RxWe       out  1       RX buffer write strobe, 1 cycle
//  Busy       out  1       transfer in progress
//  Done       out  1       1-cycle pulse on normal completion
//  ByteCount  out  BUF_AW  bytes completed in the current/last transfer
//  SPIClk, SPIDo out 1 / SPIDi in 1      flash/MCU bus
//  TFClk, TFDo   out 1 / TFDi in 1       TF card bus
//  nFlashSel, nMCUSel, nTFSel  out 1     active-low chip selects
// BEHAVIOUR
//  Reset: state IDLE; all Clk outputs 0, Do outputs 1, chip selects 1, Busy/Done/RxWe 0,
//   TxAddr/RxAddr/RxData/ByteCount 0. Reset mid-transfer aborts with no Done.
//  Chip selects: registered decode of DevSel, updated only in IDLE; held constant while Busy.
//  Start in IDLE (no Abort): latch Length, Mode, DevSel, ClkDiv; count=0; ByteCount=0;
//   Busy=1 from the next cycle -> FETCH.
//  FETCH (1 cyc): TxAddr=count -> LOAD.
//  LOAD (1 cyc): shreg = (Mode==1) ? 8'hFF : TxData; Do = shreg[7] -> SHIFT.
//  SHIFT: 8 bits, each = low half then high half, 2**ClkDiv cycles each. End of low half:
//   Clk->1, sample Di into shreg LSB side. End of high half: Clk->0, Do = next bit.
//   After the 8th high half, Clk 0 -> STORE.
//  STORE (1 cyc): if Mode!=0: RxWe=1, RxAddr=count, RxData=received byte. ByteCount=count+1.
//   If count==Length -> IDLE with Done=1 and Busy=0 in same cycle; else count++ -> FETCH.
//  Bus routing: DevSel==3 drives TFClk/TFDo and samples TFDi; otherwise SPIClk/SPIDo/SPIDi.
//   Idle bus always Clk=0, Do=1. Do returns to 1 in IDLE.
//  Byte cost: 3 + 16*2**ClkDiv cycles (19 at ClkDiv=0). Length=0 -> exactly 1 byte;
//   Length=2**BUF_AW-1 -> full buffer, count never wraps.
//  Abort in any non-IDLE state: next cycle IDLE, Clk 0, Do 1, Busy 0, no Done, no further
//   RxWe; ByteCount holds bytes completed. Abort+Start same IDLE cycle: Abort wins.
//  Start while Busy: ignored. Input changes while Busy: no effect (latched values used).
// TESTING
//  1 DevSel=1,Mode=2,ClkDiv=0,Length=0,TxData[0]=A5, SPIDi loopback -> nFlashSel=0,
//    8 SPIClk pulses, SPIDo=1010_0101, RxWe once RxAddr=0 RxData=A5, Done 19 cyc after Busy.
//  2 DevSel=3,Mode=1,ClkDiv=2,Length=3,TFDi=0 -> TFDo stays 1, SPIClk idle, 4 RxWe writes of
//    00 at addr 0..3, each byte 67 cycles, ByteCount=4 at Done.
//  3 Mode=0,Length=1FF -> 512 TX fetches addr 0..1FF, no RxWe, single Done, ByteCount=0 (wrap of
//    9-bit field) with no extra byte.
//  4 Abort after 5 SPIClk rising edges of byte 2 -> next cycle Busy=0, SPIClk=0, SPIDo=1,
//    no Done, ByteCount=2; following Start runs normally.
//  5 Start while Busy, DevSel change while Busy, Start+Abort in IDLE -> no effect on
//    transfer or chip selects; no transfer started.
//  6 nReset low mid-SHIFT -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl
//  Multi-byte SPI transfer sequencer (SPI mode 0, MSB first) for the SPI_CNT path.
//  Each byte is fetched from the TX buffer, shifted out on either the flash/MCU bus or
//  the TF bus, and the received byte is written to the RX buffer. Single clock domain
//  (FastClk); Start/Abort arrive already synchronised.
module spi_xfer_ctrl #(
    parameter int BUF_AW = 9,
    parameter int DIV_W  = 3
) (
    input  logic              FastClk,
    input  logic              nReset,
    input  logic              Start,
    input  logic              Abort,
    input  logic [BUF_AW-1:0] Length,
    input  logic [1:0]        Mode,
    input  logic [1:0]        DevSel,
    input  logic [DIV_W-1:0]  ClkDiv,
    output logic [BUF_AW-1:0] TxAddr,
    input  logic [7:0]        TxData,
    output logic [BUF_AW-1:0] RxAddr,
    output logic [7:0]        RxData,
    output logic              RxWe,
    output logic              Busy,
    output logic              Done,
    output logic [BUF_AW-1:0] ByteCount,
    output logic              SPIClk,
    output logic              SPIDo,
    input  logic              SPIDi,
    output logic              TFClk,
    output logic              TFDo,
    input  logic              TFDi,
    output logic              nFlashSel,
    output logic              nMCUSel,
    output logic              nTFSel
);

    // Half-period counter must reach 2**(2**DIV_W - 1) - 1 at the largest divider.
    localparam int CNT_W = (1 << DIV_W) - 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_STORE = 3'd4
    } state_t;

    // Active-low chip-select decode, packed as {nTF, nMCU, nFlash}.
    function automatic logic [2:0] cs_decode(input logic [1:0] dev);
        logic [2:0] cs_n;
        case (dev)
            2'd1:    cs_n = 3'b110;
            2'd2:    cs_n = 3'b101;
            2'd3:    cs_n = 3'b011;
            default: cs_n = 3'b111;
        endcase
        return cs_n;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;

    logic [BUF_AW-1:0] r_len,       w_len_nxt;
    logic [1:0]        r_mode,      w_mode_nxt;
    logic [1:0]        r_dev,       w_dev_nxt;
    logic [DIV_W-1:0]  r_div,       w_div_nxt;
    logic [BUF_AW-1:0] r_count,     w_count_nxt;
    logic [CNT_W-1:0]  r_div_cnt,   w_div_cnt_nxt;
    logic              r_high,      w_high_nxt;
    logic [2:0]        r_bit,       w_bit_nxt;
    logic [7:0]        r_shreg,     w_shreg_nxt;
    logic              r_clk,       w_clk_nxt;
    logic              r_do,        w_do_nxt;
    logic [BUF_AW-1:0] r_tx_addr,   w_tx_addr_nxt;
    logic [BUF_AW-1:0] r_rx_addr,   w_rx_addr_nxt;
    logic [7:0]        r_rx_data,   w_rx_data_nxt;
    logic              r_rx_we,     w_rx_we_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_busy,      w_busy_nxt;
    logic [BUF_AW-1:0] r_byte_cnt,  w_byte_cnt_nxt;

    logic              r_spi_clk, r_spi_do, r_tf_clk, r_tf_do;
    logic [2:0]        r_cs_n;

    logic [CNT_W-1:0]  w_half_max;
    logic              w_half_end;
    logic              w_di;
    logic [7:0]        w_load_byte;
    logic              w_tf_nxt;
    logic              w_abort;

    // Half-period length is a power of two; the wrap at the top divider is intentional.
    assign w_half_max  = (CNT_W'(1'b1) << r_div) - CNT_W'(1'b1);
    assign w_half_end  = (r_div_cnt == w_half_max);
    assign w_di        = (r_dev == 2'd3) ? TFDi : SPIDi;
    assign w_load_byte = (r_mode == 2'd1) ? 8'hFF : TxData;
    assign w_tf_nxt    = (w_dev_nxt == 2'd3);
    assign w_abort     = Abort && (r_state != S_IDLE);

    // State register.
    always_ff @(posedge FastClk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath next-value logic; Abort overrides whatever the state chose.
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_mode_nxt     = r_mode;
        w_dev_nxt      = r_dev;
        w_div_nxt      = r_div;
        w_count_nxt    = r_count;
        w_div_cnt_nxt  = r_div_cnt;
        w_high_nxt     = r_high;
        w_bit_nxt      = r_bit;
        w_shreg_nxt    = r_shreg;
        w_clk_nxt      = r_clk;
        w_do_nxt       = r_do;
        w_tx_addr_nxt  = r_tx_addr;
        w_rx_addr_nxt  = r_rx_addr;
        w_rx_data_nxt  = r_rx_data;
        w_rx_we_nxt    = 1'b0;
        w_done_nxt     = 1'b0;
        w_busy_nxt     = 1'b0;
        w_byte_cnt_nxt = r_byte_cnt;

        case (r_state)
            S_IDLE: begin
                w_clk_nxt = 1'b0;
                w_do_nxt  = 1'b1;
                if (Start && !Abort) begin
                    w_len_nxt      = Length;
                    w_mode_nxt     = Mode;
                    w_dev_nxt      = DevSel;
                    w_div_nxt      = ClkDiv;
                    w_count_nxt    = {BUF_AW{1'b0}};
                    w_byte_cnt_nxt = {BUF_AW{1'b0}};
                    w_tx_addr_nxt  = {BUF_AW{1'b0}};
                    w_state_nxt    = S_FETCH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: begin
                // TxAddr already holds count; buffer data appears next cycle.
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_shreg_nxt   = w_load_byte;
                w_do_nxt      = w_load_byte[7];
                w_clk_nxt     = 1'b0;
                w_div_cnt_nxt = {CNT_W{1'b0}};
                w_high_nxt    = 1'b0;
                w_bit_nxt     = 3'd0;
                w_state_nxt   = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_half_end) begin
                    w_div_cnt_nxt = {CNT_W{1'b0}};
                    if (!r_high) begin
                        // Rising edge: sample Di; shifted-up TX bits stay in the top.
                        w_clk_nxt   = 1'b1;
                        w_shreg_nxt = {r_shreg[6:0], w_di};
                        w_high_nxt  = 1'b1;
                    end else begin
                        w_clk_nxt  = 1'b0;
                        w_high_nxt = 1'b0;
                        if (r_bit == 3'd7) begin
                            w_do_nxt    = 1'b1;
                            w_state_nxt = S_STORE;
                        end else begin
                            w_bit_nxt = r_bit + 3'd1;
                            w_do_nxt  = r_shreg[7];
                        end
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + CNT_W'(1'b1);
                end
            end
            S_STORE: begin
                if (r_mode != 2'd0) begin
                    w_rx_we_nxt   = 1'b1;
                    w_rx_addr_nxt = r_count;
                    w_rx_data_nxt = r_shreg;
                end else begin
                    w_rx_we_nxt = 1'b0;
                end
                // ByteCount wraps to 0 on a full-buffer transfer; count itself never wraps.
                w_byte_cnt_nxt = r_count + BUF_AW'(1'b1);
                if (r_count == r_len) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_count_nxt   = r_count + BUF_AW'(1'b1);
                    w_tx_addr_nxt = r_count + BUF_AW'(1'b1);
                    w_state_nxt   = S_FETCH;
                end
            end
            default: begin
                w_clk_nxt   = 1'b0;
                w_do_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_abort) begin
            w_state_nxt    = S_IDLE;
            w_clk_nxt      = 1'b0;
            w_do_nxt       = 1'b1;
            w_rx_we_nxt    = 1'b0;
            w_done_nxt     = 1'b0;
            w_rx_addr_nxt  = r_rx_addr;
            w_rx_data_nxt  = r_rx_data;
            w_byte_cnt_nxt = r_byte_cnt;
            w_busy_nxt     = 1'b0;
        end else begin
            w_busy_nxt = (w_state_nxt != S_IDLE);
        end
    end

    // Datapath and output registers; the idle bus is always Clk=0, Do=1.
    always_ff @(posedge FastClk or negedge nReset) begin
        if (!nReset) begin
            r_len      <= {BUF_AW{1'b0}};
            r_mode     <= 2'd0;
            r_dev      <= 2'd0;
            r_div      <= {DIV_W{1'b0}};
            r_count    <= {BUF_AW{1'b0}};
            r_div_cnt  <= {CNT_W{1'b0}};
            r_high     <= 1'b0;
            r_bit      <= 3'd0;
            r_shreg    <= 8'h00;
            r_clk      <= 1'b0;
            r_do       <= 1'b1;
            r_tx_addr  <= {BUF_AW{1'b0}};
            r_rx_addr  <= {BUF_AW{1'b0}};
            r_rx_data  <= 8'h00;
            r_rx_we    <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_byte_cnt <= {BUF_AW{1'b0}};
            r_spi_clk  <= 1'b0;
            r_spi_do   <= 1'b1;
            r_tf_clk   <= 1'b0;
            r_tf_do    <= 1'b1;
        end else begin
            r_len      <= w_len_nxt;
            r_mode     <= w_mode_nxt;
            r_dev      <= w_dev_nxt;
            r_div      <= w_div_nxt;
            r_count    <= w_count_nxt;
            r_div_cnt  <= w_div_cnt_nxt;
            r_high     <= w_high_nxt;
            r_bit      <= w_bit_nxt;
            r_shreg    <= w_shreg_nxt;
            r_clk      <= w_clk_nxt;
            r_do       <= w_do_nxt;
            r_tx_addr  <= w_tx_addr_nxt;
            r_rx_addr  <= w_rx_addr_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_we    <= w_rx_we_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= w_busy_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_spi_clk  <= w_tf_nxt ? 1'b0 : w_clk_nxt;
            r_spi_do   <= w_tf_nxt ? 1'b1 : w_do_nxt;
            r_tf_clk   <= w_tf_nxt ? w_clk_nxt : 1'b0;
            r_tf_do    <= w_tf_nxt ? w_do_nxt : 1'b1;
        end
    end

    // Chip selects track DevSel only while idle and are frozen for the whole transfer.
    always_ff @(posedge FastClk or negedge nReset) begin
        if (!nReset) begin
            r_cs_n <= 3'b111;
        end else if (r_state == S_IDLE) begin
            r_cs_n <= cs_decode(DevSel);
        end else begin
            r_cs_n <= r_cs_n;
        end
    end

    assign TxAddr    = r_tx_addr;
    assign RxAddr    = r_rx_addr;
    assign RxData    = r_rx_data;
    assign RxWe      = r_rx_we;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign ByteCount = r_byte_cnt;
    assign SPIClk    = r_spi_clk;
    assign SPIDo     = r_spi_do;
    assign TFClk     = r_tf_clk;
    assign TFDo      = r_tf_do;
    assign nFlashSel = r_cs_n[0];
    assign nMCUSel   = r_cs_n[1];
    assign nTFSel    = r_cs_n[2];

endmodule
